// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory-controller request port among NPORT
// requesters, with header parity check, write-data bursts and credit throttling.
module mem_req_arbiter #(
  parameter  int NPORT   = 4,
  parameter  int NCREDIT = 4,
  parameter  int WBEATS  = 2,
  parameter  int TIDW    = 6,
  parameter  int ADDRW   = 27,
  localparam int RIDW    = $clog2(NPORT),
  localparam int CW      = $clog2(NCREDIT + 1),
  localparam int BW      = (WBEATS > 1) ? $clog2(WBEATS) : 1
) (
  input  logic                   gclk,
  input  logic                   rstn,
  input  logic [NPORT-1:0]       req_valid,
  input  logic [NPORT-1:0]       req_we,
  input  logic [NPORT*TIDW-1:0]  req_tid,
  input  logic [NPORT*ADDRW-1:0] req_addr,
  input  logic [NPORT-1:0]       req_parity,
  output logic [NPORT-1:0]       req_re,
  output logic [NPORT-1:0]       wdata_re,
  output logic                   mc_valid,
  output logic                   mc_we,
  output logic [TIDW-1:0]        mc_tid,
  output logic [ADDRW-1:0]       mc_addr,
  output logic [RIDW-1:0]        mc_rid,
  output logic                   mc_wvalid,
  output logic [BW-1:0]          mc_wbeat,
  output logic [RIDW-1:0]        mc_wsel,
  input  logic                   credit_ret,
  output logic [CW-1:0]          ccnt,
  output logic                   perr,
  output logic [7:0]             perr_cnt,
  output logic                   cred_ovf
);

  typedef enum logic {ARB, WDATA} state_e;

  state_e           state_q, state_d;
  logic [RIDW-1:0]  rr_q, rr_d;
  logic [CW-1:0]    ccnt_q, ccnt_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             drop_q, drop_d;
  logic [7:0]       pcnt_q, pcnt_d;
  logic             ovf_q, ovf_d;
  logic             mcv_q, mcv_d;
  logic             perr_q, perr_d;
  logic             we_q, we_d;
  logic [TIDW-1:0]  tid_q, tid_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [RIDW-1:0]  rid_q, rid_d;

  logic [RIDW-1:0]  win;
  logic             any_v, grant, par_ok, issue;
  logic             sel_we;
  logic [TIDW-1:0]  sel_tid;
  logic [ADDRW-1:0] sel_addr;

  // Scan downward in priority so the port closest to rr_q (upward, wrapping) wins last.
  always_comb begin
    logic [RIDW-1:0] idx;
    win   = '0;
    any_v = 1'b0;
    idx   = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      idx = rr_q + RIDW'(i);
      if (req_valid[idx]) begin
        win   = idx;
        any_v = 1'b1;
      end
    end
  end

  assign sel_we   = req_we[win];
  assign sel_tid  = req_tid[win*TIDW +: TIDW];
  assign sel_addr = req_addr[win*ADDRW +: ADDRW];
  assign par_ok   = ~(^{sel_we, sel_tid, sel_addr, req_parity[win]});
  assign grant    = (state_q == ARB) && any_v && (ccnt_q != '0);
  assign issue    = grant && par_ok;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ccnt_d  = ccnt_q;
    beat_d  = beat_q;
    drop_d  = drop_q;
    pcnt_d  = pcnt_q;
    ovf_d   = ovf_q;
    we_d    = we_q;
    tid_d   = tid_q;
    addr_d  = addr_q;
    rid_d   = rid_q;
    mcv_d   = issue;
    perr_d  = grant && !par_ok;

    if (grant) begin
      we_d   = sel_we;
      tid_d  = sel_tid;
      addr_d = sel_addr;
      rid_d  = win;
      rr_d   = win + RIDW'(1);
      if (sel_we) begin
        state_d = WDATA;
        beat_d  = '0;
        drop_d  = !par_ok;
      end
    end

    if (state_q == WDATA) begin
      if (beat_q == BW'(WBEATS - 1)) begin
        state_d = ARB;
        beat_d  = '0;
        drop_d  = 1'b0;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end

    if (perr_d && (pcnt_q != 8'hFF)) pcnt_d = pcnt_q + 8'd1;

    // A return with the counter already full and nothing issued is an accounting error.
    if (credit_ret && !issue && (ccnt_q == CW'(NCREDIT))) begin
      ovf_d = 1'b1;
    end else if (issue && !credit_ret) begin
      ccnt_d = ccnt_q - CW'(1);
    end else if (!issue && credit_ret) begin
      ccnt_d = ccnt_q + CW'(1);
    end
  end

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB;
      rr_q    <= '0;
      ccnt_q  <= CW'(NCREDIT);
      beat_q  <= '0;
      drop_q  <= 1'b0;
      pcnt_q  <= '0;
      ovf_q   <= 1'b0;
      mcv_q   <= 1'b0;
      perr_q  <= 1'b0;
      we_q    <= 1'b0;
      tid_q   <= '0;
      addr_q  <= '0;
      rid_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ccnt_q  <= ccnt_d;
      beat_q  <= beat_d;
      drop_q  <= drop_d;
      pcnt_q  <= pcnt_d;
      ovf_q   <= ovf_d;
      mcv_q   <= mcv_d;
      perr_q  <= perr_d;
      we_q    <= we_d;
      tid_q   <= tid_d;
      addr_q  <= addr_d;
      rid_q   <= rid_d;
    end
  end

  // Pops are held off while reset is asserted so buffers are never drained during reset.
  assign req_re    = (grant && rstn) ? (NPORT'(1) << win) : '0;
  assign wdata_re  = (state_q == WDATA) ? (NPORT'(1) << rid_q) : '0;
  assign mc_valid  = mcv_q;
  assign mc_we     = we_q;
  assign mc_tid    = tid_q;
  assign mc_addr   = addr_q;
  assign mc_rid    = rid_q;
  assign mc_wvalid = (state_q == WDATA) && !drop_q;
  assign mc_wbeat  = beat_q;
  assign mc_wsel   = rid_q;
  assign ccnt      = ccnt_q;
  assign perr      = perr_q;
  assign perr_cnt  = pcnt_q;
  assign cred_ovf  = ovf_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_req_arbiter;
  localparam int NPORT = 4, NCREDIT = 4, WBEATS = 2, TIDW = 6, ADDRW = 27;
  localparam int RIDW = 2, CW = 3, BW = 1;

  logic                   gclk = 1'b0;
  logic                   rstn = 1'b1;
  logic [NPORT-1:0]       req_valid = '0;
  logic [NPORT-1:0]       req_we = '0;
  logic [NPORT*TIDW-1:0]  req_tid = '0;
  logic [NPORT*ADDRW-1:0] req_addr = '0;
  logic [NPORT-1:0]       req_parity = '0;
  logic                   credit_ret = 1'b0;
  logic [NPORT-1:0]       req_re, wdata_re;
  logic                   mc_valid, mc_we, mc_wvalid, perr, cred_ovf;
  logic [TIDW-1:0]        mc_tid;
  logic [ADDRW-1:0]       mc_addr;
  logic [RIDW-1:0]        mc_rid, mc_wsel;
  logic [BW-1:0]          mc_wbeat;
  logic [CW-1:0]          ccnt;
  logic [7:0]             perr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mem_req_arbiter #(.NPORT(NPORT), .NCREDIT(NCREDIT), .WBEATS(WBEATS), .TIDW(TIDW), .ADDRW(ADDRW)) dut (
    .gclk(gclk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we), .req_tid(req_tid),
    .req_addr(req_addr), .req_parity(req_parity), .req_re(req_re), .wdata_re(wdata_re),
    .mc_valid(mc_valid), .mc_we(mc_we), .mc_tid(mc_tid), .mc_addr(mc_addr), .mc_rid(mc_rid),
    .mc_wvalid(mc_wvalid), .mc_wbeat(mc_wbeat), .mc_wsel(mc_wsel), .credit_ret(credit_ret),
    .ccnt(ccnt), .perr(perr), .perr_cnt(perr_cnt), .cred_ovf(cred_ovf)
  );

  always #5 gclk = ~gclk;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of the arbiter as transactions: pointer, credit pool, remaining burst beats.
  int               m_rr = 0, m_cred = NCREDIT, m_busy = 0, m_wport = 0, m_pcnt = 0, m_rid = 0;
  bit               m_drop = 0, m_valid = 0, m_perr = 0, m_ovf = 0, m_we = 0;
  logic [TIDW-1:0]  m_tid = '0;
  logic [ADDRW-1:0] m_addr = '0;

  always @(negedge gclk) begin : model_chk
    int w;
    bit g, ok, iss;
    logic sw;
    logic [TIDW-1:0] st;
    logic [ADDRW-1:0] sa;
    if (!rstn) begin
      cmp("rst_pops", {req_re, wdata_re}, 64'd0);
      cmp("rst_mc", {mc_valid, mc_we, mc_tid, mc_addr, mc_rid, mc_wvalid, mc_wbeat, mc_wsel}, 64'd0);
      cmp("rst_ccnt", ccnt, 64'(NCREDIT));
      cmp("rst_err", {perr, perr_cnt, cred_ovf}, 64'd0);
      m_rr = 0; m_cred = NCREDIT; m_busy = 0; m_wport = 0; m_pcnt = 0; m_rid = 0;
      m_drop = 0; m_valid = 0; m_perr = 0; m_ovf = 0; m_we = 0; m_tid = '0; m_addr = '0;
    end else begin
      g = 0; w = 0;
      if (m_busy == 0 && m_cred > 0)
        for (int i = 0; i < NPORT; i++)
          if (!g && req_valid[(m_rr + i) % NPORT]) begin g = 1; w = (m_rr + i) % NPORT; end
      cmp("req_re", req_re, g ? (64'd1 << w) : 64'd0);
      cmp("wdata_re", wdata_re, (m_busy > 0) ? (64'd1 << m_wport) : 64'd0);
      cmp("mc_wvalid", mc_wvalid, 64'(m_busy > 0 && !m_drop));
      cmp("mc_wbeat", mc_wbeat, (m_busy > 0) ? 64'(WBEATS - m_busy) : 64'd0);
      cmp("mc_wsel", mc_wsel, 64'(m_rid));
      cmp("mc_valid", mc_valid, 64'(m_valid));
      cmp("mc_hdr", {mc_we, mc_tid, mc_addr}, {m_we, m_tid, m_addr});
      cmp("mc_rid", mc_rid, 64'(m_rid));
      cmp("ccnt", ccnt, 64'(m_cred));
      cmp("perr", perr, 64'(m_perr));
      cmp("perr_cnt", perr_cnt, 64'(m_pcnt));
      cmp("cred_ovf", cred_ovf, 64'(m_ovf));

      sw = req_we[w];
      st = req_tid[w*TIDW +: TIDW];
      sa = req_addr[w*ADDRW +: ADDRW];
      ok = ((^{sw, st, sa}) == req_parity[w]);
      iss = g && ok;
      m_valid = iss;
      m_perr = g && !ok;
      if (m_perr && m_pcnt < 255) m_pcnt++;
      if (m_busy > 0) m_busy--;
      if (g) begin
        m_we = sw; m_tid = st; m_addr = sa; m_rid = w;
        m_rr = (w + 1) % NPORT;
        if (sw) begin m_busy = WBEATS; m_drop = !ok; m_wport = w; end
      end
      if (credit_ret && !iss && m_cred == NCREDIT) m_ovf = 1;
      else m_cred = m_cred + (credit_ret ? 1 : 0) - (iss ? 1 : 0);
    end
  end

  task automatic drive_port(input int p, input bit v, input bit we,
                            input logic [TIDW-1:0] t, input logic [ADDRW-1:0] a, input bit bad);
    req_valid[p] = v;
    req_we[p] = we;
    req_tid[p*TIDW +: TIDW] = t;
    req_addr[p*ADDRW +: ADDRW] = a;
    req_parity[p] = (^{we, t, a}) ^ bad;
  endtask

  task automatic set_port(input int p, input bit v, input bit we, input bit bad);
    drive_port(p, v, we, TIDW'(p * 5 + 1), ADDRW'(32'h100 * (p + 1) + 3), bad);
  endtask

  task automatic nxt();
    @(posedge gclk);
    #1;
  endtask

  initial begin
    #1 rstn = 1'b0;
    for (int p = 0; p < NPORT; p++) set_port(p, 1, 0, 0);
    repeat (3) nxt();
    #1;
    cmp("lit_reset_req_re", req_re, 0);
    cmp("lit_reset_ccnt", ccnt, 4);

    // Four reads drain the credit pool in port order.
    nxt(); rstn = 1'b1; #1;
    cmp("lit_rr0", req_re, 4'b0001);
    nxt(); #1;
    cmp("lit_rr1", req_re, 4'b0010); cmp("lit_rid0", mc_rid, 0); cmp("lit_c3", ccnt, 3);
    nxt(); #1;
    cmp("lit_rr2", req_re, 4'b0100); cmp("lit_c2", ccnt, 2);
    nxt(); #1;
    cmp("lit_rr3", req_re, 4'b1000); cmp("lit_c1", ccnt, 1);
    nxt(); #1;
    cmp("lit_stall", req_re, 0); cmp("lit_c0", ccnt, 0); cmp("lit_rid3", mc_rid, 3);
    nxt(); credit_ret = 1'b1; #1;
    cmp("lit_stall2", req_re, 0);
    nxt(); credit_ret = 1'b0; #1;
    cmp("lit_ret_c1", ccnt, 1); cmp("lit_ret_grant0", req_re, 4'b0001);
    nxt(); for (int p = 0; p < NPORT; p++) set_port(p, 0, 0, 0); #1;
    cmp("lit_c0b", ccnt, 0); cmp("lit_v0", mc_valid, 1);

    // Issue and return together at ccnt==1, then overflow at full.
    nxt(); credit_ret = 1'b1; #1;
    nxt(); set_port(1, 1, 0, 0); #1;
    cmp("lit_c1b", ccnt, 1); cmp("lit_grant1", req_re, 4'b0010);
    nxt(); credit_ret = 1'b0; set_port(1, 0, 0, 0); #1;
    cmp("lit_both_c1", ccnt, 1); cmp("lit_rid1", mc_rid, 1);
    nxt(); credit_ret = 1'b1;
    nxt(); nxt(); nxt(); #1;
    cmp("lit_full", ccnt, 4); cmp("lit_noovf", cred_ovf, 0);
    nxt(); credit_ret = 1'b0; #1;
    cmp("lit_ovf_c4", ccnt, 4); cmp("lit_ovf", cred_ovf, 1);

    // Write on port 2 with a read waiting on port 3.
    nxt(); set_port(2, 1, 1, 0); set_port(3, 1, 0, 0); #1;
    cmp("lit_w_grant", req_re, 4'b0100);
    nxt(); set_port(2, 0, 0, 0); #1;
    cmp("lit_w_hdr", {mc_valid, mc_we, mc_wvalid}, 3'b111); cmp("lit_w_b0", mc_wbeat, 0);
    cmp("lit_w_wd0", wdata_re, 4'b0100); cmp("lit_w_hold", req_re, 0);
    nxt(); #1;
    cmp("lit_w_b1", mc_wbeat, 1); cmp("lit_w_wd1", wdata_re, 4'b0100);
    cmp("lit_w_v0", mc_valid, 0); cmp("lit_w_hold1", req_re, 0);
    nxt(); #1;
    cmp("lit_w_next3", req_re, 4'b1000); cmp("lit_w_done", wdata_re, 0);
    nxt(); set_port(3, 0, 0, 0); #1;
    cmp("lit_w_c2", ccnt, 2);

    // Bad-parity read on port 1, then port 2 follows.
    nxt(); set_port(1, 1, 0, 1); set_port(2, 1, 0, 0); #1;
    cmp("lit_pe_grant", req_re, 4'b0010);
    nxt(); set_port(1, 0, 0, 0); #1;
    cmp("lit_pe_pulse", perr, 1); cmp("lit_pe_cnt", perr_cnt, 1);
    cmp("lit_pe_nov", mc_valid, 0); cmp("lit_pe_c", ccnt, 2); cmp("lit_pe_next", req_re, 4'b0100);
    nxt(); set_port(2, 0, 0, 0); #1;
    cmp("lit_pe_off", perr, 0); cmp("lit_pe_c1", ccnt, 1);

    // Bad-parity write on port 3: data popped and discarded.
    nxt(); set_port(3, 1, 1, 1); #1;
    nxt(); set_port(3, 0, 0, 0); #1;
    cmp("lit_pw_wd0", wdata_re, 4'b1000); cmp("lit_pw_wv0", mc_wvalid, 0);
    cmp("lit_pw_cnt", perr_cnt, 2);
    nxt(); #1;
    cmp("lit_pw_wd1", wdata_re, 4'b1000); cmp("lit_pw_wv1", mc_wvalid, 0);
    nxt(); #1;
    cmp("lit_pw_c", ccnt, 1);

    // Reset during beat 0 of a write.
    nxt(); set_port(0, 1, 1, 0); #1;
    nxt(); set_port(0, 0, 0, 0); #1;
    cmp("lit_rw_b0", {mc_valid, mc_wvalid, wdata_re}, 6'b110001);
    rstn = 1'b0; #1;
    cmp("lit_rw_clr", {mc_valid, mc_wvalid, wdata_re}, 0); cmp("lit_rw_c4", ccnt, 4);
    nxt(); nxt(); rstn = 1'b1; set_port(0, 1, 0, 0); set_port(3, 1, 0, 0); #1;
    cmp("lit_rw_rr0", req_re, 4'b0001);
    nxt(); set_port(0, 0, 0, 0); set_port(3, 0, 0, 0); credit_ret = 1'b1; #1;
    nxt(); credit_ret = 1'b0;

    // Saturation of the parity error counter.
    set_port(0, 1, 0, 1);
    repeat (300) nxt();
    set_port(0, 0, 0, 0); #1;
    cmp("lit_sat", perr_cnt, 255);

    for (int c = 0; c < 3000; c++) begin
      nxt();
      rstn = (c % 700 != 350);
      for (int p = 0; p < NPORT; p++)
        drive_port(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   TIDW'($urandom), ADDRW'($urandom), ($urandom_range(0, 7) == 0));
      credit_ret = ($urandom_range(0, 2) == 0);
    end
    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Round-robin arbiter that shares one memory-controller request port among NPORT memory-network requesters (I- and D-side request address buffers of each pipeline). It pops one request header per grant, checks its parity, and issues it with its requestor ID. Writes are followed by a fixed-length data burst. Issue is throttled by a credit counter replenished by the memory controller. It sits between the per-port request address/data buffers and the memory controller input.

## Interface
- NPORT, 4: requester count, power of two ≥2 (NMEMCTRLPORT*2)
- NCREDIT, 4: max outstanding requests at the controller
- WBEATS, 2: write data beats following a write header
- TIDW, 6: thread id width (NTHREADIDMSB+1)
- ADDRW, 27: request address width (bits 31:ICACHEINDEXLSB_MEM, burst aligned)
- RIDW = log2(NPORT): derived requestor ID width
- CW = clog2(NCREDIT+1): derived credit counter width

Ports:
- gclk in 1: clock
- rstn in 1: asynchronous active-low reset
- req_valid in NPORT: header buffer non-empty, per port
- req_we in NPORT: header write bit
- req_tid in NPORT*TIDW: header thread id, port p at [p*TIDW+:TIDW]
- req_addr in NPORT*ADDRW: header address, packed the same way as req_tid
- req_parity in NPORT: even parity over {we,tid,addr}
- req_re out NPORT: one-hot header pop
- wdata_re out NPORT: one-hot data-buffer pop
- mc_valid out 1: header valid, one cycle
- mc_we out 1: issued header write bit
- mc_tid out TIDW: issued header thread id
- mc_addr out ADDRW: issued header address
- mc_rid out RIDW: issued requestor ID
- mc_wvalid out 1: write data beat valid
- mc_wbeat out log2(WBEATS): beat index of the current data beat
- mc_wsel out RIDW: port whose data buffer feeds the controller
- credit_ret in 1: controller frees one credit
- ccnt out CW: current credit count
- perr out 1: parity-error pulse
- perr_cnt out 8: saturating parity-error count
- cred_ovf out 1: sticky flag, credit returned while ccnt==NCREDIT

## Operation
- States: ARB, WDATA.
- ARB: if any req_valid and ccnt>0, the winner is the first valid port searching from rr_ptr upward, modulo NPORT.
  - Assert req_re[winner] combinationally this cycle.
  - Latch the header and RIDW=winner into mc_* regs.
  - Set rr_ptr=winner+1 (wraps).
- Parity ok: mc_valid=1 the next cycle for exactly one cycle; ccnt decrements. If we=1 go to WDATA, else stay in ARB. Back-to-back reads issue one per cycle.
- Parity bad: no mc_valid, no credit consumed, perr pulses the next cycle, perr_cnt increments and saturates at 255, rr_ptr still advances. If we=1 go to WDATA with the drop flag set.
- ccnt==0: no grant and no req_re; requests wait.
- WDATA: runs for WBEATS cycles.
  - wdata_re[mc_wsel]=1 every cycle.
  - mc_wbeat counts 0..WBEATS-1.
  - mc_wvalid=1 unless dropping; when dropping the data is popped and discarded.
  - After the last beat return to ARB; no arbitration happens in WDATA.
- Credits: ccnt_next = ccnt − issue + credit_ret.
  - Simultaneous issue and return leaves ccnt unchanged.
  - A return at ccnt==NCREDIT without an issue is ignored and sets cred_ovf.
- Reset: state=ARB, rr_ptr=0, ccnt=NCREDIT, beat=0, drop=0, perr_cnt=0, cred_ovf=0. All outputs 0 except ccnt. Reset mid-WDATA aborts the burst immediately; remaining data stays in the buffer.

## Timing
- Grant to mc_valid: 1 cycle; mc_* header regs hold until the next grant.
- Write: the first WDATA cycle coincides with mc_valid (header and beat 0 together). The header occupies the port for 1+WBEATS cycles including the grant cycle.
- req_re and wdata_re are combinational from registered state plus req_valid/ccnt. Buffers pop on the same edge the arbiter latches.
- Credit return is visible in ccnt the next cycle and can enable a grant in that cycle.
- All flops on posedge gclk, async clear on negedge rstn.

## Test plan
- Reset, then all 4 ports issue valid reads: grants in order 0,1,2,3 on consecutive cycles, then stall at ccnt=0. Each credit_ret produces exactly one more grant, continuing round-robin from port 0.
- Port 2 issues a write with WBEATS=2 while port 3 has a read pending: mc_valid and beat 0 come in cycle t+1, beat 1 in t+2, wdata_re[2] is asserted in both, and port 3 is granted at t+3.
- Bad-parity read on port 1: perr pulses once, perr_cnt=1, no mc_valid, ccnt unchanged, port 2 granted next cycle. Bad-parity write: wdata_re asserted for 2 cycles with mc_wvalid=0.
- Issue and credit_ret in the same cycle with ccnt=1: ccnt stays 1. credit_ret at ccnt=4 with no issue: ccnt stays 4 and cred_ovf=1.
- Assert rstn low during beat 0 of a write: outputs clear asynchronously. After release the state is ARB, ccnt=4, rr_ptr=0.
- 300 bad-parity headers: perr_cnt saturates at 255.
